// File: rtl/bp_pkg.sv
// Shared types and constants for the branch-predictor update path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bp_pkg;

    localparam int PC_W  = 16;
    localparam int IDX_W = 4;
    localparam int CNT_W = 2;

    // Counter table reset value: weakly not-taken.
    localparam logic [CNT_W-1:0] CNT_INIT = 2'b01;

    // Tag table reset value; a branch at PC FFFF therefore never predicts.
    localparam logic [PC_W-1:0] TAG_INVALID = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } bp_state_t;

    // Queued update layout for the default widths (the top rebuilds it per its parameters).
    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic [PC_W-1:0]  pc;
        logic             taken;
        logic [PC_W-1:0]  target;
    } bp_entry_t;

endpackage

// File: rtl/bp_upd_fifo.sv
// Pending-update queue: synchronous FIFO with clear, full/empty flags and occupancy count.
// Latency: a push is visible at the head the cycle after the accepting edge.
// Backpressure: pushes while full and pops while empty are ignored; clear beats push and pop.
module bp_upd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_clear,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_dat,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_head,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    // Storage array; contents need no reset because the count gates visibility.
    always_ff @(posedge clk) begin
        if (w_push && !i_clear) begin
            r_mem[r_wr_ptr] <= i_dat;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at a power-of-2 depth.
    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

endmodule

// File: rtl/bp_update_unit.sv
// Branch-predictor write-side controller: queues resolved branches, RMWs the 2-bit counter, writes tag/target.
// Latency: event accepted at E0 into an idle unit -> READ after E1 -> WRITE after E2 -> committed at E3.
// Backpressure: upd_ready = !full (no pass-through on a same-cycle pop); flush drops queued work and new events.
module bp_update_unit
    import bp_pkg::*;
#(
    parameter int PC_WIDTH    = 16,
    parameter int INDEX_WIDTH = 4,
    parameter int IDX_LSB     = 0,
    parameter int CNT_WIDTH   = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   upd_valid,
    output logic                   upd_ready,
    input  logic [PC_WIDTH-1:0]    upd_pc,
    input  logic                   upd_taken,
    input  logic [PC_WIDTH-1:0]    upd_target,
    input  logic                   flush,
    output logic [INDEX_WIDTH-1:0] cnt_rd_addr,
    input  logic [CNT_WIDTH-1:0]   cnt_rd_data,
    output logic                   cnt_wr_en,
    output logic [INDEX_WIDTH-1:0] cnt_wr_addr,
    output logic [CNT_WIDTH-1:0]   cnt_wr_data,
    output logic                   tag_wr_en,
    output logic [INDEX_WIDTH-1:0] tag_wr_addr,
    output logic [PC_WIDTH-1:0]    tag_wr_data,
    output logic [PC_WIDTH-1:0]    tgt_wr_data,
    output logic                   busy
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    typedef struct packed {
        logic [INDEX_WIDTH-1:0] idx;
        logic [PC_WIDTH-1:0]    pc;
        logic                   taken;
        logic [PC_WIDTH-1:0]    target;
    } upd_entry_t;

    bp_state_t  r_state;
    upd_entry_t w_new;
    upd_entry_t w_head;
    logic       w_full;
    logic       w_empty;
    logic [CW-1:0] w_count;
    logic       w_push;
    logic       w_pop;
    logic       w_more;

    // Saturating 2-bit-style counter step: up on taken, down on not-taken, clamped at both ends.
    function automatic logic [CNT_WIDTH-1:0] f_sat_step(input logic [CNT_WIDTH-1:0] cnt,
                                                        input logic             taken);
        if (taken) begin
            return (cnt == '1) ? cnt : cnt + CNT_WIDTH'(1);
        end
        return (cnt == '0) ? cnt : cnt - CNT_WIDTH'(1);
    endfunction

    assign w_new.idx    = upd_pc[IDX_LSB+INDEX_WIDTH-1:IDX_LSB];
    assign w_new.pc     = upd_pc;
    assign w_new.taken  = upd_taken;
    assign w_new.target = upd_target;

    assign upd_ready = !w_full;
    // A flush in the same cycle discards the incoming event.
    assign w_push    = upd_valid && upd_ready && !flush;
    assign w_pop     = (r_state == ST_WRITE);
    // Entries left after this edge's pop, counting any event arriving on the same edge.
    assign w_more    = (w_count > CW'(1)) || w_push;

    assign cnt_rd_addr = w_empty ? '0 : w_head.idx;
    assign busy        = (r_state != ST_IDLE) || !w_empty;

    bp_upd_fifo #(
        .WIDTH ($bits(upd_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_clear (flush),
        .i_push  (w_push),
        .i_dat   (w_new),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Update FSM with registered table-write outputs; one update every two cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            cnt_wr_en   <= 1'b0;
            cnt_wr_addr <= '0;
            cnt_wr_data <= '0;
            tag_wr_en   <= 1'b0;
            tag_wr_addr <= '0;
            tag_wr_data <= '0;
            tgt_wr_data <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    cnt_wr_en <= 1'b0;
                    tag_wr_en <= 1'b0;
                    if (!w_empty && !flush) begin
                        r_state <= ST_READ;
                    end
                end
                ST_READ: begin
                    if (flush) begin
                        // Not yet started writing: drop it entirely.
                        r_state <= ST_IDLE;
                    end else begin
                        r_state     <= ST_WRITE;
                        cnt_wr_en   <= 1'b1;
                        cnt_wr_addr <= w_head.idx;
                        cnt_wr_data <= f_sat_step(cnt_rd_data, w_head.taken);
                        // Only taken branches allocate a tag/target entry.
                        tag_wr_en   <= w_head.taken;
                        tag_wr_addr <= w_head.idx;
                        tag_wr_data <= w_head.pc;
                        tgt_wr_data <= w_head.target;
                    end
                end
                ST_WRITE: begin
                    // The write presented this cycle commits regardless of flush.
                    cnt_wr_en <= 1'b0;
                    tag_wr_en <= 1'b0;
                    if (!flush && w_more) begin
                        r_state <= ST_READ;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    cnt_wr_en <= 1'b0;
                    tag_wr_en <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bp_update_unit.sv
module tb_bp_update_unit;
    import bp_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        upd_valid;
    logic        upd_ready;
    logic [15:0] upd_pc;
    logic        upd_taken;
    logic [15:0] upd_target;
    logic        flush;
    logic [3:0]  cnt_rd_addr;
    logic [1:0]  cnt_rd_data;
    logic        cnt_wr_en;
    logic [3:0]  cnt_wr_addr;
    logic [1:0]  cnt_wr_data;
    logic        tag_wr_en;
    logic [3:0]  tag_wr_addr;
    logic [15:0] tag_wr_data;
    logic [15:0] tgt_wr_data;
    logic        busy;

    int checks = 0;
    int errors = 0;

    // Table models and write log
    logic        tbl_init;
    logic [1:0]  cnt_tbl [16];
    logic [15:0] tag_tbl [16];
    logic [3:0]  lg_addr [64];
    logic [1:0]  lg_data [64];
    logic        lg_tag_en [64];
    logic [3:0]  lg_tag_addr [64];
    logic [15:0] lg_tag [64];
    logic [15:0] lg_tgt [64];
    int          lg_cyc [64];
    int          n_wr = 0;
    int          cyc = 0;

    always #5 clk = ~clk;

    bp_update_unit dut (
        .clk         (clk),
        .reset       (reset),
        .upd_valid   (upd_valid),
        .upd_ready   (upd_ready),
        .upd_pc      (upd_pc),
        .upd_taken   (upd_taken),
        .upd_target  (upd_target),
        .flush       (flush),
        .cnt_rd_addr (cnt_rd_addr),
        .cnt_rd_data (cnt_rd_data),
        .cnt_wr_en   (cnt_wr_en),
        .cnt_wr_addr (cnt_wr_addr),
        .cnt_wr_data (cnt_wr_data),
        .tag_wr_en   (tag_wr_en),
        .tag_wr_addr (tag_wr_addr),
        .tag_wr_data (tag_wr_data),
        .tgt_wr_data (tgt_wr_data),
        .busy        (busy)
    );

    assign cnt_rd_data = cnt_tbl[cnt_rd_addr];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (tbl_init) begin
            for (int i = 0; i < 16; i++) begin
                cnt_tbl[i] <= CNT_INIT;
                tag_tbl[i] <= TAG_INVALID;
            end
        end else begin
            if (cnt_wr_en) begin
                cnt_tbl[cnt_wr_addr] <= cnt_wr_data;
                lg_addr[n_wr]     <= cnt_wr_addr;
                lg_data[n_wr]     <= cnt_wr_data;
                lg_tag_en[n_wr]   <= tag_wr_en;
                lg_tag_addr[n_wr] <= tag_wr_addr;
                lg_tag[n_wr]      <= tag_wr_data;
                lg_tgt[n_wr]      <= tgt_wr_data;
                lg_cyc[n_wr]      <= cyc;
                n_wr <= n_wr + 1;
            end
            if (tag_wr_en) begin
                tag_tbl[tag_wr_addr] <= tag_wr_data;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one event for one edge; acc reports whether it was accepted.
    task automatic enq(input logic [15:0] pc, input logic tk, input logic [15:0] tgt, output logic acc);
        upd_valid  = 1'b1;
        upd_pc     = pc;
        upd_taken  = tk;
        upd_target = tgt;
        @(negedge clk);
        acc = upd_ready && !flush;
        step();
        upd_valid = 1'b0;
    endtask

    task automatic wait_writes(input int target, input string name);
        for (int i = 0; i < 60 && n_wr < target; i++) step();
        checks++;
        if (n_wr !== target) begin
            errors++;
            $display("FAIL %s write count got %0d want %0d", name, n_wr, target);
        end
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 60 && busy; i++) step();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s busy stuck got %b want 0", name, busy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; tbl_init = 1'b1;
        upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0; flush = 1'b0;
        repeat (3) step();
        reset = 1'b0; tbl_init = 1'b0;
        checks++; if (cnt_wr_en !== 1'b0) begin errors++; $display("FAIL rst_cnt_wr_en got %b want 0", cnt_wr_en); end
        checks++; if (tag_wr_en !== 1'b0) begin errors++; $display("FAIL rst_tag_wr_en got %b want 0", tag_wr_en); end
        checks++; if (upd_ready !== 1'b1) begin errors++; $display("FAIL rst_upd_ready got %b want 1", upd_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
        checks++; if (cnt_rd_addr !== 4'd0) begin errors++; $display("FAIL rst_rd_addr got %0d want 0", cnt_rd_addr); end
        checks++; if ({cnt_wr_addr, cnt_wr_data, tag_wr_addr, tag_wr_data, tgt_wr_data} !== 42'd0) begin
            errors++; $display("FAIL rst_wr_data got %h want 0", {cnt_wr_addr, cnt_wr_data, tag_wr_addr, tag_wr_data, tgt_wr_data});
        end
    endtask

    task automatic test_single();
        logic acc;
        int base;
        base = n_wr;
        enq(16'h0013, 1'b1, 16'h0040, acc);          // edge E0
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b want 1", busy); end
        step();                                        // E1: now READ
        checks++; if (cnt_rd_addr !== 4'd3) begin errors++; $display("FAIL single_rd_addr got %0d want 3", cnt_rd_addr); end
        checks++; if (cnt_wr_en !== 1'b0) begin errors++; $display("FAIL single_en_in_read got %b want 0", cnt_wr_en); end
        step();                                        // E2: now WRITE
        checks++; if ({cnt_wr_en, cnt_wr_addr, cnt_wr_data} !== {1'b1, 4'd3, 2'd2}) begin
            errors++; $display("FAIL single_cnt_wr got en=%b a=%0d d=%0d want en=1 a=3 d=2", cnt_wr_en, cnt_wr_addr, cnt_wr_data);
        end
        checks++; if ({tag_wr_en, tag_wr_addr, tag_wr_data, tgt_wr_data} !== {1'b1, 4'd3, 16'h0013, 16'h0040}) begin
            errors++; $display("FAIL single_tag_wr got en=%b a=%0d tag=%h tgt=%h want en=1 a=3 tag=0013 tgt=0040",
                               tag_wr_en, tag_wr_addr, tag_wr_data, tgt_wr_data);
        end
        step();                                        // E3: committed
        checks++; if ({cnt_wr_en, busy} !== 2'b00) begin errors++; $display("FAIL single_after got en=%b busy=%b want 0 0", cnt_wr_en, busy); end
        checks++; if (n_wr !== base + 1) begin errors++; $display("FAIL single_nwr got %0d want %0d", n_wr, base + 1); end
        checks++; if (tag_tbl[3] !== 16'h0013) begin errors++; $display("FAIL single_tag_tbl got %h want 0013", tag_tbl[3]); end
    endtask

    task automatic test_back_to_back();
        logic acc;
        int base;
        logic [1:0] exp_d [4];
        exp_d[0] = 2'd2; exp_d[1] = 2'd3; exp_d[2] = 2'd3; exp_d[3] = 2'd3;
        base = n_wr;
        for (int i = 0; i < 4; i++) enq(16'h0005, 1'b1, 16'h0100, acc);
        wait_writes(base + 4, "b2b");
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({lg_addr[base+i], lg_data[base+i]} !== {4'd5, exp_d[i]}) begin
                errors++; $display("FAIL b2b_wr%0d got a=%0d d=%0d want a=5 d=%0d", i, lg_addr[base+i], lg_data[base+i], exp_d[i]);
            end
        end
        for (int i = 1; i < 4; i++) begin
            checks++;
            if (lg_cyc[base+i] - lg_cyc[base+i-1] !== 2) begin
                errors++; $display("FAIL b2b_spacing%0d got %0d want 2", i, lg_cyc[base+i] - lg_cyc[base+i-1]);
            end
        end
        wait_idle("b2b");
    endtask

    task automatic test_not_taken();
        logic acc;
        int base;
        base = n_wr;
        enq(16'h0007, 1'b0, 16'h0200, acc);
        enq(16'h0007, 1'b0, 16'h0200, acc);
        wait_writes(base + 2, "nt");
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({lg_addr[base+i], lg_data[base+i], lg_tag_en[base+i]} !== {4'd7, 2'd0, 1'b0}) begin
                errors++; $display("FAIL nt_wr%0d got a=%0d d=%0d tag_en=%b want a=7 d=0 tag_en=0",
                                   i, lg_addr[base+i], lg_data[base+i], lg_tag_en[base+i]);
            end
        end
        checks++; if (tag_tbl[7] !== TAG_INVALID) begin errors++; $display("FAIL nt_tag_tbl got %h want ffff", tag_tbl[7]); end
        wait_idle("nt");
    endtask

    task automatic test_flush();
        logic acc;
        int base;
        base = n_wr;
        enq(16'h0008, 1'b1, 16'h0300, acc);
        enq(16'h0009, 1'b1, 16'h0301, acc);
        enq(16'h000A, 1'b1, 16'h0302, acc);           // now in first WRITE
        checks++; if ({cnt_wr_en, cnt_wr_addr, busy} !== {1'b1, 4'd8, 1'b1}) begin
            errors++; $display("FAIL flush_pre got en=%b a=%0d busy=%b want 1 8 1", cnt_wr_en, cnt_wr_addr, busy);
        end
        flush = 1'b1;
        step();
        flush = 1'b0;
        checks++; if ({busy, cnt_wr_en} !== 2'b00) begin errors++; $display("FAIL flush_busy got busy=%b en=%b want 0 0", busy, cnt_wr_en); end
        repeat (10) step();
        checks++; if (n_wr !== base + 1) begin errors++; $display("FAIL flush_nwr got %0d want %0d", n_wr, base + 1); end
        checks++; if ({cnt_tbl[8], cnt_tbl[9], cnt_tbl[10]} !== {2'd2, 2'd1, 2'd1}) begin
            errors++; $display("FAIL flush_tbl got %0d %0d %0d want 2 1 1", cnt_tbl[8], cnt_tbl[9], cnt_tbl[10]);
        end
    endtask

    task automatic test_reset_in_read();
        logic acc;
        logic saw_wr;
        int base;
        base = n_wr;
        saw_wr = 1'b0;
        enq(16'h000B, 1'b1, 16'h0400, acc);
        step();                                        // READ
        checks++; if (cnt_rd_addr !== 4'd11) begin errors++; $display("FAIL rrd_rd_addr got %0d want 11", cnt_rd_addr); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++; if ({upd_ready, busy} !== 2'b10) begin errors++; $display("FAIL rrd_state got ready=%b busy=%b want 1 0", upd_ready, busy); end
        for (int i = 0; i < 6; i++) begin
            if (cnt_wr_en || tag_wr_en) saw_wr = 1'b1;
            step();
        end
        checks++; if (saw_wr !== 1'b0) begin errors++; $display("FAIL rrd_no_pulse got %b want 0", saw_wr); end
        checks++; if (n_wr !== base || cnt_tbl[11] !== 2'd1) begin
            errors++; $display("FAIL rrd_nowrite got nwr=%0d tbl=%0d want %0d 1", n_wr, cnt_tbl[11], base);
        end
    endtask

    task automatic test_full_pop();
        logic acc;
        logic [5:0] acc_v;
        int base;
        logic [15:0] pcs [6];
        pcs[0] = 16'h000C; pcs[1] = 16'h000D; pcs[2] = 16'h000E;
        pcs[3] = 16'h000F; pcs[4] = 16'h0010; pcs[5] = 16'h0001;
        base = n_wr;
        for (int i = 0; i < 6; i++) begin
            enq(pcs[i], 1'b1, 16'h0500, acc);
            acc_v[i] = acc;
        end
        checks++; if (acc_v !== 6'b011111) begin errors++; $display("FAIL full_accept got %b want 011111", acc_v); end
        wait_writes(base + 5, "full");
        repeat (6) step();
        checks++; if (n_wr !== base + 5) begin errors++; $display("FAIL full_nwr got %0d want %0d", n_wr, base + 5); end
        checks++; if ({cnt_tbl[1], cnt_tbl[0], cnt_tbl[12]} !== {2'd1, 2'd2, 2'd2}) begin
            errors++; $display("FAIL full_tbl got %0d %0d %0d want 1 2 2", cnt_tbl[1], cnt_tbl[0], cnt_tbl[12]);
        end
        wait_idle("full");
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_not_taken();
        test_flush();
        test_reset_in_read();
        test_full_pop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
